// File: rtl/calc_pkg.sv
// Shared definitions for pipelined_calc: function codes, FSM states and
// instruction field offsets.
package calc_pkg;

    localparam logic [2:0] F_ADD    = 3'd0;
    localparam logic [2:0] F_SUB    = 3'd1;
    localparam logic [2:0] F_ADDACC = 3'd2;
    localparam logic [2:0] F_SUBACC = 3'd3;
    localparam logic [2:0] F_MUL    = 3'd4;
    localparam logic [2:0] F_MULACC = 3'd5;
    localparam logic [2:0] F_CLR    = 3'd6;
    localparam logic [2:0] F_NOP    = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam int FUNCT_W  = 3;
    localparam int IMM_A_LO = FUNCT_W;

    function automatic int imm_b_lo(input int imm_w);
        return IMM_A_LO + imm_w;
    endfunction

    function automatic int instr_used_w(input int imm_w);
        return IMM_A_LO + 2 * imm_w;
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, IMM_W cycles
// per product, with the MSB step subtracted in signed mode.
module seq_mul
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IMM_W      = 14,
    parameter int IMM_SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [IMM_W-1:0] i_mplier,
    output logic             o_busy,
    output logic             o_last,
    output logic [WIDTH-1:0] o_product,
    output logic             o_negative,
    output logic             o_overflow
);

    localparam int PW  = WIDTH + IMM_W;
    localparam int CW  = $clog2(IMM_W + 1);
    localparam bit SGN = (IMM_SIGNED != 0);
    localparam logic [CW-1:0] LAST = CW'(IMM_W - 1);

    logic                 r_busy;
    logic [CW-1:0]        r_count;
    logic signed [PW-1:0] r_mcand;
    logic signed [PW-1:0] r_prod;
    logic [IMM_W-1:0]     r_mplier;
    logic signed [PW-1:0] w_term;
    logic signed [PW-1:0] w_prod_next;
    logic [IMM_W:0]       w_hi;
    logic                 w_neg_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
        end else if (r_busy) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST)
                r_busy <= 1'b0;
        end
    end

    // Multiplicand shifts left and multiplier shifts right so each step only
    // ever looks at multiplier bit 0.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_mcand  <= {{IMM_W{SGN & i_mcand[WIDTH-1]}}, i_mcand};
            r_mplier <= i_mplier;
            r_prod   <= '0;
        end else if (r_busy) begin
            r_mcand  <= r_mcand <<< 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_next;
        end
    end

    always_comb begin
        w_neg_step  = SGN && (r_count == LAST);
        w_term      = r_mplier[0] ? r_mcand : '0;
        w_prod_next = w_neg_step ? (r_prod - w_term) : (r_prod + w_term);
        w_hi        = w_prod_next[PW-1:WIDTH-1];
        if (SGN)
            o_overflow = (w_hi != '0) && (w_hi != '1);
        else
            o_overflow = (w_hi[IMM_W:1] != '0);
    end

    assign o_busy     = r_busy;
    assign o_last     = r_busy && (r_count == LAST);
    assign o_product  = w_prod_next[WIDTH-1:0];
    assign o_negative = SGN & w_prod_next[PW-1];

endmodule

// File: rtl/pipelined_calc.sv
// Accumulator calculator: single-cycle add/sub/clear/nop plus an iterative
// multiply, with optional signed immediates and saturating results.
module pipelined_calc
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IMM_W      = 14,
    parameter int INSTR_W    = 32,
    parameter int IMM_SIGNED = 0,
    parameter int SATURATE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               overflow,
    output logic               busy
);

    localparam bit SGN    = (IMM_SIGNED != 0);
    localparam bit SAT    = (SATURATE != 0);
    localparam int B_LO   = imm_b_lo(IMM_W);
    localparam int USED_W = instr_used_w(IMM_W);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic             r_done;

    logic [2:0]       w_funct;
    logic [IMM_W-1:0] w_imm_a;
    logic [IMM_W-1:0] w_imm_b;
    logic [WIDTH-1:0] w_a_ext;
    logic [WIDTH-1:0] w_b_ext;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_lhs;
    logic [WIDTH-1:0] w_rhs;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_as_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_mul_busy;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_prod;
    logic             w_mul_neg;
    logic             w_mul_ovf;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_mcand;

    function automatic logic [WIDTH-1:0] extend(input logic [IMM_W-1:0] v);
        return {{(WIDTH-IMM_W){SGN & v[IMM_W-1]}}, v};
    endfunction

    // low selects the lower clamp: min-negative (signed) or zero (unsigned).
    function automatic logic [WIDTH-1:0] sat_value(input logic low);
        logic [WIDTH-1:0] v;
        if (SGN)
            v = low ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            v = low ? '0 : '1;
        return v;
    endfunction

    assign w_funct  = instruction[2:0];
    assign w_imm_a  = instruction[IMM_A_LO +: IMM_W];
    assign w_imm_b  = instruction[B_LO +: IMM_W];
    assign w_a_ext  = extend(w_imm_a);
    assign w_b_ext  = extend(w_imm_b);
    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (w_funct == F_MUL) || (w_funct == F_MULACC);
    assign w_mcand  = (w_funct == F_MULACC) ? r_acc : w_b_ext;

    generate
        if (INSTR_W > USED_W) begin : g_spare
            logic w_unused_bits;
            assign w_unused_bits = ^instruction[INSTR_W-1:USED_W];
        end
    endgenerate

    always_comb begin
        w_lhs = w_a_ext;
        w_rhs = ((w_funct == F_ADDACC) || (w_funct == F_SUBACC)) ? r_acc : w_b_ext;
        w_sub = (w_funct == F_SUB) || (w_funct == F_SUBACC);
        w_sum = w_sub ? ({1'b0, w_lhs} - {1'b0, w_rhs}) : ({1'b0, w_lhs} + {1'b0, w_rhs});
        if (SGN)
            w_as_ovf = ((w_lhs[WIDTH-1] ^ w_rhs[WIDTH-1]) == w_sub)
                       && (w_sum[WIDTH-1] != w_lhs[WIDTH-1]);
        else
            w_as_ovf = w_sum[WIDTH];

        w_alu_res = r_acc;
        w_alu_ovf = 1'b0;
        case (w_funct)
            F_ADD, F_SUB, F_ADDACC, F_SUBACC: begin
                w_alu_ovf = w_as_ovf;
                // On signed overflow the true result carries the sign of A.
                w_alu_res = (SAT && w_as_ovf) ? sat_value(SGN ? w_lhs[WIDTH-1] : w_sub)
                                              : w_sum[WIDTH-1:0];
            end
            F_CLR:   w_alu_res = '0;
            default: w_alu_res = r_acc;
        endcase
    end

    seq_mul #(
        .WIDTH      (WIDTH),
        .IMM_W      (IMM_W),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept && w_is_mul),
        .i_mcand    (w_mcand),
        .i_mplier   (w_imm_a),
        .o_busy     (w_mul_busy),
        .o_last     (w_mul_last),
        .o_product  (w_mul_prod),
        .o_negative (w_mul_neg),
        .o_overflow (w_mul_ovf)
    );

    assign w_mul_res = (SAT && w_mul_ovf) ? sat_value(w_mul_neg) : w_mul_prod;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_next_state = S_MUL;
            S_MUL:   if (w_mul_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Accumulator update: accepting edge for single-cycle ops, final
    // iteration edge for multiplies; the two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_acc  <= w_alu_res;
                r_ovf  <= w_alu_ovf;
                r_done <= 1'b1;
            end else if (w_mul_last) begin
                r_acc  <= w_mul_res;
                r_ovf  <= w_mul_ovf;
                r_done <= 1'b1;
            end
        end
    end

    assign result   = r_acc;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign busy     = w_mul_busy;

endmodule

// File: tb/tb_pipelined_calc.sv
// Bench for pipelined_calc: three configurations share one instruction stream
// and are compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_calc;

    localparam int NDUT    = 3;
    localparam int MUL_CYC = 14;
    localparam logic [2:0] F_ADD = 3'd0, F_SUB = 3'd1, F_ADDACC = 3'd2, F_SUBACC = 3'd3;
    localparam logic [2:0] F_MUL = 3'd4, F_MULACC = 3'd5, F_CLR = 3'd6, F_NOP = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     instruction = '0;
    logic [31:0]     res0, res1;
    logic [15:0]     res2;
    logic [NDUT-1:0] done_v, ovf_v, busy_v, rdy_v;

    int n_checks = 0;
    int n_err = 0;

    longint     m_acc [NDUT];
    bit         m_ovf [NDUT];
    longint     p_acc [NDUT];
    bit         p_ovf [NDUT];
    int         mul_left = 0;
    bit         e_done = 1'b0;
    logic [2:0] cur_f = '0;
    logic [13:0] cur_a = '0, cur_b = '0;

    always #5 clk = ~clk;

    pipelined_calc #(.WIDTH(32), .IMM_W(14), .INSTR_W(32), .IMM_SIGNED(0), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .instruction(instruction), .result(res0), .done(done_v[0]),
        .overflow(ovf_v[0]), .busy(busy_v[0]));

    pipelined_calc #(.WIDTH(32), .IMM_W(14), .INSTR_W(32), .IMM_SIGNED(0), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .instruction(instruction), .result(res1), .done(done_v[1]),
        .overflow(ovf_v[1]), .busy(busy_v[1]));

    pipelined_calc #(.WIDTH(16), .IMM_W(14), .INSTR_W(32), .IMM_SIGNED(1), .SATURATE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .instruction(instruction), .result(res2), .done(done_v[2]),
        .overflow(ovf_v[2]), .busy(busy_v[2]));

    function automatic logic [31:0] res_of(input int d);
        case (d)
            0:       return res0;
            1:       return res1;
            default: return {16'h0, res2};
        endcase
    endfunction

    function automatic int cfg_w(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    // Reference: compute the true mathematical result, then wrap or clamp it
    // into the configuration's representable range.
    function automatic void alu_model(input int d, input logic [2:0] f, input logic [13:0] a,
                                      input logic [13:0] b, input longint acc_in,
                                      output longint acc_out, output bit ov);
        longint one = 1;
        int     w   = cfg_w(d);
        bit     sg  = (d == 2);
        bit     st  = (d != 0);
        longint va, vb, vacc, r, lo, hi;
        va = a;
        vb = b;
        vacc = acc_in;
        if (sg && a[13]) va = va - 16384;
        if (sg && b[13]) vb = vb - 16384;
        if (sg && acc_in[w-1]) vacc = vacc - (one << w);
        case (f)
            F_ADD:    r = va + vb;
            F_SUB:    r = va - vb;
            F_ADDACC: r = va + vacc;
            F_SUBACC: r = va - vacc;
            F_MUL:    r = va * vb;
            F_MULACC: r = va * vacc;
            F_CLR:    r = 0;
            default:  r = vacc;
        endcase
        lo = sg ? -(one << (w - 1)) : 0;
        hi = sg ? (one << (w - 1)) - 1 : (one << w) - 1;
        ov = (r < lo) || (r > hi);
        if (ov && st) r = (r < lo) ? lo : hi;
        acc_out = r & ((one << w) - 1);
    endfunction

    task automatic drive(input bit v, input logic [2:0] f, input logic [13:0] a, input logic [13:0] b);
        cur_f = f;
        cur_a = a;
        cur_b = b;
        in_valid = v;
        instruction = {1'($urandom_range(0, 1)), b, a, f};
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
        end
        mul_left = 0;
        e_done = 1'b0;
    endtask

    // One clock: advance the model at the rising edge, return on the falling edge.
    task automatic tick();
        longint na;
        bit     no;
        @(posedge clk);
        e_done = 1'b0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                for (int d = 0; d < NDUT; d++) begin
                    m_acc[d] = p_acc[d];
                    m_ovf[d] = p_ovf[d];
                end
                e_done = 1'b1;
            end
        end else if (in_valid) begin
            for (int d = 0; d < NDUT; d++) begin
                alu_model(d, cur_f, cur_a, cur_b, m_acc[d], na, no);
                if (cur_f == F_MUL || cur_f == F_MULACC) begin
                    p_acc[d] = na;
                    p_ovf[d] = no;
                end else begin
                    m_acc[d] = na;
                    m_ovf[d] = no;
                end
            end
            if (cur_f == F_MUL || cur_f == F_MULACC) mul_left = MUL_CYC;
            else e_done = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== 32'h0 || done_v[d] !== 1'b0 || ovf_v[d] !== 1'b0 ||
                busy_v[d] !== 1'b0 || rdy_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL reset dut%0d got res=%h done=%b ovf=%b busy=%b rdy=%b want 0/0/0/0/1",
                         d, res_of(d), done_v[d], ovf_v[d], busy_v[d], rdy_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_back_to_back();
        drive(1'b1, F_ADD, 14'd5, 14'd3);
        tick();
        n_checks++;
        if (done_v[0] !== 1'b1 || res_of(0) !== 32'd8 || ovf_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL add_5_3 got done=%b res=%0d ovf=%b rdy=%b want 1/8/0/1",
                     done_v[0], res_of(0), ovf_v[0], rdy_v[0]);
        end
        drive(1'b1, F_ADD, 14'd20, 14'd22);
        tick();
        n_checks++;
        if (done_v[0] !== 1'b1 || res_of(0) !== 32'd42) begin
            n_err++;
            $display("FAIL add_back_to_back got done=%b res=%0d want 1/42", done_v[0], res_of(0));
        end
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (done_v[d] !== 1'b0 || res_of(d) !== m_acc[d][31:0]) begin
                n_err++;
                $display("FAIL idle_after_add dut%0d got done=%b res=%h want 0/%h",
                         d, done_v[d], res_of(d), m_acc[d][31:0]);
            end
        end
    endtask

    task automatic test_sub();
        drive(1'b1, F_SUB, 14'd3, 14'd5);
        tick();
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        n_checks++;
        if (res_of(0) !== 32'hFFFF_FFFE || ovf_v[0] !== 1'b1 || done_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sub_wrap got res=%h ovf=%b done=%b want fffffffe/1/1", res_of(0), ovf_v[0], done_v[0]);
        end
        n_checks++;
        if (res_of(1) !== 32'h0 || ovf_v[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sub_sat got res=%h ovf=%b want 0/1", res_of(1), ovf_v[1]);
        end
        n_checks++;
        if (res_of(2) !== 32'h0000_FFFE || ovf_v[2] !== 1'b0) begin
            n_err++;
            $display("FAIL sub_signed got res=%h ovf=%b want fffe/0", res_of(2), ovf_v[2]);
        end
        tick();
    endtask

    task automatic test_sat_clamp();
        drive(1'b1, F_CLR, 14'd0, 14'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, F_ADDACC, 14'h1FFF, 14'($urandom));
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (res_of(d) !== m_acc[d][31:0] || ovf_v[d] !== m_ovf[d] || done_v[d] !== 1'b1) begin
                    n_err++;
                    $display("FAIL addacc_step%0d dut%0d got res=%h ovf=%b done=%b want %h/%b/1",
                             i, d, res_of(d), ovf_v[d], done_v[d], m_acc[d][31:0], m_ovf[d]);
                end
            end
        end
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        n_checks++;
        if (res2 !== 16'h7FFF || ovf_v[2] !== 1'b1) begin
            n_err++;
            $display("FAIL signed_clamp got res=%h ovf=%b want 7fff/1", res2, ovf_v[2]);
        end
        tick();
    endtask

    task automatic test_mul();
        drive(1'b1, F_MUL, 14'd100, 14'd200);
        tick();
        for (int i = 1; i <= MUL_CYC; i++) begin
            n_checks++;
            if (busy_v[0] !== 1'b1 || rdy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
                n_err++;
                $display("FAIL mul_busy cyc%0d got busy=%b rdy=%b done=%b want 1/0/0",
                         i, busy_v[0], rdy_v[0], done_v[0]);
            end
            drive((i % 2 == 0) || (i == MUL_CYC), F_ADD, 14'd1, 14'd1);
            tick();
        end
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        n_checks++;
        if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1 || res_of(0) !== 32'd20000) begin
            n_err++;
            $display("FAIL mul_done got done=%b busy=%b rdy=%b res=%0d want 1/0/1/20000",
                     done_v[0], busy_v[0], rdy_v[0], res_of(0));
        end
        for (int d = 1; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== m_acc[d][31:0] || ovf_v[d] !== m_ovf[d]) begin
                n_err++;
                $display("FAIL mul_cfg dut%0d got res=%h ovf=%b want %h/%b",
                         d, res_of(d), ovf_v[d], m_acc[d][31:0], m_ovf[d]);
            end
        end
        drive(1'b1, F_MULACC, 14'd3, 14'h3FFF);
        tick();
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        repeat (MUL_CYC - 1) tick();
        n_checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mulacc_early got done=%b busy=%b want 0/1", done_v[0], busy_v[0]);
        end
        tick();
        n_checks++;
        if (done_v[0] !== 1'b1 || res_of(0) !== 32'd60000 || ovf_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mulacc got done=%b res=%0d ovf=%b want 1/60000/0", done_v[0], res_of(0), ovf_v[0]);
        end
        for (int d = 1; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== m_acc[d][31:0] || ovf_v[d] !== m_ovf[d]) begin
                n_err++;
                $display("FAIL mulacc_cfg dut%0d got res=%h ovf=%b want %h/%b",
                         d, res_of(d), ovf_v[d], m_acc[d][31:0], m_ovf[d]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int seen_done = 0;
        drive(1'b1, F_MUL, 14'd100, 14'd200);
        tick();
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== 32'h0 || done_v[d] !== 1'b0 || ovf_v[d] !== 1'b0 ||
                busy_v[d] !== 1'b0 || rdy_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_mid_mul dut%0d got res=%h done=%b ovf=%b busy=%b rdy=%b want 0/0/0/0/1",
                         d, res_of(d), done_v[d], ovf_v[d], busy_v[d], rdy_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (MUL_CYC + 2) begin
            tick();
            if (done_v != '0) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_err++;
            $display("FAIL reset_discard got %0d done pulses want 0", seen_done);
        end
        drive(1'b1, F_ADD, 14'd1, 14'd1);
        tick();
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== 32'd2 || done_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL add_after_reset dut%0d got res=%h done=%b want 2/1", d, res_of(d), done_v[d]);
            end
        end
        tick();
    endtask

    task automatic test_clr_nop();
        drive(1'b1, F_SUB, 14'd0, 14'd1);
        tick();
        drive(1'b1, F_NOP, 14'd0, 14'd0);
        tick();
        n_checks++;
        if (res_of(0) !== 32'hFFFF_FFFF || ovf_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL nop_after_ovf got res=%h ovf=%b done=%b want ffffffff/0/1", res_of(0), ovf_v[0], done_v[0]);
        end
        drive(1'b1, F_SUB, 14'd0, 14'd1);
        tick();
        drive(1'b1, F_CLR, 14'h3FFF, 14'h3FFF);
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== 32'h0 || ovf_v[d] !== 1'b0 || done_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL clr dut%0d got res=%h ovf=%b done=%b want 0/0/1", d, res_of(d), ovf_v[d], done_v[d]);
            end
        end
        drive(1'b1, F_ADD, 14'd9, 14'd4);
        tick();
        drive(1'b1, F_NOP, 14'd5, 14'd6);
        tick();
        drive(1'b0, F_NOP, 14'd0, 14'd0);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (res_of(d) !== 32'd13 || ovf_v[d] !== 1'b0 || done_v[d] !== 1'b1) begin
                n_err++;
                $display("FAIL nop dut%0d got res=%h ovf=%b done=%b want 13/0/1", d, res_of(d), ovf_v[d], done_v[d]);
            end
        end
        tick();
    endtask

    function automatic logic [13:0] pick_imm();
        case ($urandom_range(0, 4))
            0:       return 14'h0000;
            1:       return 14'h3FFF;
            2:       return 14'h2000;
            3:       return 14'h1FFF;
            default: return 14'($urandom);
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                n_checks++;
                if (done_v[d] !== e_done || rdy_v[d] !== (mul_left == 0) || busy_v[d] !== (mul_left > 0) ||
                    res_of(d) !== m_acc[d][31:0] || ovf_v[d] !== m_ovf[d]) begin
                    n_err++;
                    $display("FAIL random cyc%0d dut%0d got done=%b rdy=%b busy=%b res=%h ovf=%b want %b/%b/%b/%h/%b",
                             c, d, done_v[d], rdy_v[d], busy_v[d], res_of(d), ovf_v[d],
                             e_done, (mul_left == 0), (mul_left > 0), m_acc[d][31:0], m_ovf[d]);
                end
            end
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_imm(), pick_imm());
            tick();
        end
        drive(1'b0, F_NOP, 14'd0, 14'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_back_to_back();
        test_sub();
        test_sat_clamp();
        test_mul();
        test_reset_mid_mul();
        test_clr_nop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
